ir_nec_decoder: RTL and testbench

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

---
 rtl/ir_pkg.sv | 41 ++++
 rtl/ir_sync_filter.sv | 41 ++++
 rtl/ir_nec_decoder.sv | 165 ++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// NEC IR decoder shared types and symbol timing windows.
// All durations are in timing ticks, as seen by the level-duration counter.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } ir_state_e;

  localparam int DUR_W  = 11;
  localparam int IDLE_W = 14;
  localparam int BITS_W = 6;

  localparam logic [DUR_W-1:0] LEAD_MARK_MIN  = 11'd800;
  localparam logic [DUR_W-1:0] LEAD_MARK_MAX  = 11'd1000;
  localparam logic [DUR_W-1:0] LEAD_SPACE_MIN = 11'd400;
  localparam logic [DUR_W-1:0] LEAD_SPACE_MAX = 11'd500;
  localparam logic [DUR_W-1:0] RPT_SPACE_MIN  = 11'd180;
  localparam logic [DUR_W-1:0] RPT_SPACE_MAX  = 11'd270;
  localparam logic [DUR_W-1:0] BIT_MARK_MIN   = 11'd40;
  localparam logic [DUR_W-1:0] BIT_MARK_MAX   = 11'd72;
  localparam logic [DUR_W-1:0] ZERO_SPACE_MIN = 11'd40;
  localparam logic [DUR_W-1:0] ZERO_SPACE_MAX = 11'd90;
  localparam logic [DUR_W-1:0] ONE_SPACE_MIN  = 11'd130;
  localparam logic [DUR_W-1:0] ONE_SPACE_MAX  = 11'd210;
  localparam logic [DUR_W-1:0] LEVEL_TIMEOUT  = 11'd1100;

  localparam logic [IDLE_W-1:0] ARM_TICKS = 14'd12000;
  localparam logic [BITS_W-1:0] LAST_BIT  = 6'd31;

  function automatic logic in_window(input logic [DUR_W-1:0] dur,
                                     input logic [DUR_W-1:0] lo,
                                     input logic [DUR_W-1:0] hi);
    return (dur >= lo) && (dur <= hi);
  endfunction

endpackage

// File: rtl/ir_sync_filter.sv
// Two-flop synchronizer plus tick-based stability filter for the raw IR line.
// A new level is accepted once two consecutive tick samples agree on it.
module ir_sync_filter (
  input  logic clk_in,
  input  logic rst_in,
  input  logic tick_in,
  input  logic raw_in,
  output logic filt_out,
  output logic rise_out,
  output logic fall_out
);

  logic sync1_q, sync2_q, samp_q, filt_q, rise_q, fall_q;
  logic accept;

  assign accept = tick_in && (sync2_q == samp_q) && (sync2_q != filt_q);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      samp_q  <= 1'b1;
      filt_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      if (tick_in) samp_q <= sync2_q;
      if (accept) filt_q <= sync2_q;
      // Edge pulses coincide with the cycle the filtered level changes.
      rise_q <= accept && sync2_q;
      fall_q <= accept && !sync2_q;
    end
  end

  assign filt_out = filt_q;
  assign rise_out = rise_q;
  assign fall_out = fall_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: measures filtered mark/space lengths in ticks
// and walks a frame FSM that emits code, repeat and error pulses.
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int CLK_HZ    = 74_250_000,
  parameter int TICK_HZ   = 100_000,
  parameter int CHECK_CMD = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ir_rx_in,
  output logic [31:0] code_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        err_out
);

  localparam int DIV   = (CLK_HZ / TICK_HZ > 1) ? (CLK_HZ / TICK_HZ) : 1;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]  pre_q;
  logic              tick_q;
  logic              filt_w, rise_w, fall_w;
  logic              mark_start, mark_end;
  logic [DUR_W-1:0]  dur_q;
  logic [IDLE_W-1:0] idle_q;

  ir_state_e         state_q;
  logic [BITS_W-1:0] bit_cnt_q;
  logic [31:0]       shift_q, code_q;
  logic              rpt_q, armed_q, valid_q, repeat_q, err_q;

  logic              lead_ok, rpt_ok, mark_ok, zero_ok, one_ok, cmd_ok;
  logic              edge_seen, sym_ok, timeout, frame_fail;
  logic [31:0]       shift_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else if (pre_q == PRE_LAST) begin
      pre_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      pre_q  <= pre_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  ir_sync_filter u_sync_filter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .tick_in  (tick_q),
    .raw_in   (ir_rx_in),
    .filt_out (filt_w),
    .rise_out (rise_w),
    .fall_out (fall_w)
  );

  assign mark_start = fall_w && !filt_w;
  assign mark_end   = rise_w && filt_w;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dur_q  <= '0;
      idle_q <= '0;
    end else begin
      if (rise_w || fall_w) dur_q <= '0;
      else if (tick_q && !(&dur_q)) dur_q <= dur_q + 1'b1;
      if (fall_w) idle_q <= '0;
      else if (tick_q && (idle_q < ARM_TICKS)) idle_q <= idle_q + 1'b1;
    end
  end

  always_comb begin
    lead_ok   = in_window(dur_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
    rpt_ok    = in_window(dur_q, RPT_SPACE_MIN, RPT_SPACE_MAX);
    mark_ok   = in_window(dur_q, BIT_MARK_MIN, BIT_MARK_MAX);
    zero_ok   = in_window(dur_q, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
    one_ok    = in_window(dur_q, ONE_SPACE_MIN, ONE_SPACE_MAX);
    cmd_ok    = (CHECK_CMD == 0) || (shift_q[15:8] == ~shift_q[7:0]);
    shift_d   = {shift_q[30:0], one_ok};
    edge_seen = mark_start;
    sym_ok    = 1'b1;
    case (state_q)
      LEAD_MARK: begin
        edge_seen = mark_end;
        sym_ok    = in_window(dur_q, LEAD_MARK_MIN, LEAD_MARK_MAX);
      end
      LEAD_SPACE: sym_ok = lead_ok || rpt_ok;
      BIT_MARK: begin
        edge_seen = mark_end;
        sym_ok    = mark_ok;
      end
      BIT_SPACE: sym_ok = zero_ok || one_ok;
      STOP_MARK: begin
        edge_seen = mark_end;
        sym_ok    = mark_ok && (rpt_q || cmd_ok);
      end
      default: ;
    endcase
    timeout    = (state_q != IDLE) && !(rise_w || fall_w) && (dur_q > LEVEL_TIMEOUT);
    frame_fail = timeout || ((state_q != IDLE) && edge_seen && !sym_ok);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      code_q    <= '0;
      rpt_q     <= 1'b0;
      armed_q   <= 1'b0;
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      err_q    <= 1'b0;
      if (idle_q == ARM_TICKS) armed_q <= 1'b0;
      if (frame_fail) begin
        err_q   <= 1'b1;
        armed_q <= 1'b0;
        state_q <= IDLE;
      end else if (edge_seen) begin
        case (state_q)
          IDLE:      state_q <= LEAD_MARK;
          LEAD_MARK: state_q <= LEAD_SPACE;
          LEAD_SPACE: begin
            rpt_q     <= !lead_ok;
            bit_cnt_q <= '0;
            state_q   <= lead_ok ? BIT_MARK : STOP_MARK;
          end
          BIT_MARK:  state_q <= BIT_SPACE;
          BIT_SPACE: begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= (bit_cnt_q == LAST_BIT) ? STOP_MARK : BIT_MARK;
          end
          STOP_MARK: begin
            state_q <= IDLE;
            // A repeat with no recent good frame is silently dropped.
            if (rpt_q) begin
              repeat_q <= armed_q;
            end else begin
              code_q  <= shift_q;
              valid_q <= 1'b1;
              armed_q <= 1'b1;
            end
          end
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  assign code_out   = code_q;
  assign valid_out  = valid_q;
  assign repeat_out = repeat_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Scoreboard bench for ir_nec_decoder: two instances (command check on/off)
// share one IR line; a 10 us clock makes every clock a timing tick.
`timescale 1us/1ns
module tb_ir_nec_decoder;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] code;
  } exp_t;

  localparam logic [1:0] K_VALID  = 2'd1;
  localparam logic [1:0] K_REPEAT = 2'd2;
  localparam logic [1:0] K_ERR    = 2'd3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir    = 1'b1;
  logic [31:0] code0, code1;
  logic        valid0, rpt0, err0, valid1, rpt1, err1;

  int errors = 0;
  int checks = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [31:0] last0 = 32'h0;
  logic [31:0] last1 = 32'h0;

  int lead_mk = 900, lead_sp = 450, bit_mk = 56, sp0 = 56, sp1 = 169;
  bit glitch_en = 1'b0;

  always #5 clk = ~clk;

  ir_nec_decoder #(.CLK_HZ(100_000), .TICK_HZ(100_000), .CHECK_CMD(1)) dut_chk (
    .clk_in(clk), .rst_in(rst_n), .ir_rx_in(ir),
    .code_out(code0), .valid_out(valid0), .repeat_out(rpt0), .err_out(err0)
  );

  ir_nec_decoder #(.CLK_HZ(100_000), .TICK_HZ(100_000), .CHECK_CMD(0)) dut_nochk (
    .clk_in(clk), .rst_in(rst_n), .ir_rx_in(ir),
    .code_out(code1), .valid_out(valid1), .repeat_out(rpt1), .err_out(err1)
  );

  function automatic string kname(input logic [1:0] k);
    case (k)
      K_VALID:  return "valid";
      K_REPEAT: return "repeat";
      K_ERR:    return "err";
      default:  return "none";
    endcase
  endfunction

  task automatic mon(input int id, input logic v, input logic r, input logic e,
                     input logic [31:0] code);
    exp_t x;
    logic [1:0] kind;
    int n;
    n = int'(v) + int'(r) + int'(e);
    if (n == 0) return;
    checks++;
    kind = v ? K_VALID : (r ? K_REPEAT : K_ERR);
    if (n > 1) begin
      errors++;
      $display("FAIL dut%0d exclusive pulses: valid=%0b repeat=%0b err=%0b, required one at a time",
               id, v, r, e);
      return;
    end
    if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL dut%0d unexpected event: got %s code=%h, required no event",
               id, kname(kind), code);
      return;
    end
    if (id == 0) x = exp_q0.pop_front();
    else         x = exp_q1.pop_front();
    if (kind != x.kind || code !== x.code) begin
      errors++;
      $display("FAIL dut%0d event: got %s code=%h, required %s code=%h",
               id, kname(kind), code, kname(x.kind), x.code);
    end else begin
      $display("dut%0d event %s code=%h ok", id, kname(kind), code);
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid0, rpt0, err0, code0);
    mon(1, valid1, rpt1, err1, code1);
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("check %s: %h ok", name, act);
    end
  endtask

  task automatic push(input int id, input logic [1:0] kind, input logic [31:0] code);
    exp_t x;
    x.kind = kind;
    x.code = code;
    if (id == 0) exp_q0.push_back(x);
    else         exp_q1.push_back(x);
  endtask

  task automatic expect_valid(input int id, input logic [31:0] code);
    if (id == 0) last0 = code;
    else         last1 = code;
    push(id, K_VALID, code);
  endtask

  task automatic expect_err(input int id);
    push(id, K_ERR, (id == 0) ? last0 : last1);
  endtask

  task automatic lvl(input logic v, input int n);
    ir = v;
    repeat (n) @(negedge clk);
  endtask

  // Optional 5 us low glitch straddling one rising clock edge mid-space.
  task automatic spc(input int n);
    ir = 1'b1;
    if (glitch_en && n >= 4) begin
      repeat (n / 2) @(negedge clk);
      #2 ir = 1'b0;
      #5 ir = 1'b1;
      repeat (n - n / 2) @(negedge clk);
    end else begin
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic set_timing(input int pct);
    lead_mk = 900 * (100 + pct) / 100;
    lead_sp = 450 * (100 + pct) / 100;
    bit_mk  = 56 * (100 + pct) / 100;
    sp0     = 56 * (100 + pct) / 100;
    sp1     = 169 * (100 + pct) / 100;
  endtask

  task automatic send_frame(input logic [31:0] code, input int nbits, input int bad_bit,
                            input int bad_sp, input bit stop);
    lvl(1'b0, lead_mk);
    spc(lead_sp);
    for (int i = 0; i < nbits; i++) begin
      lvl(1'b0, bit_mk);
      if (i == bad_bit) spc(bad_sp);
      else              spc(code[31-i] ? sp1 : sp0);
    end
    if (stop) lvl(1'b0, bit_mk);
    ir = 1'b1;
  endtask

  task automatic send_repeat();
    lvl(1'b0, lead_mk);
    spc(225);
    lvl(1'b0, bit_mk);
    ir = 1'b1;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check_eq("reset code dut0", code0, 32'h0);
    check_eq("reset code dut1", code1, 32'h0);
    check_eq("reset pulses dut0", {29'd0, valid0, rpt0, err0}, 32'h0);
    check_eq("reset pulses dut1", {29'd0, valid1, rpt1, err1}, 32'h0);
    rst_n = 1'b1;
    lvl(1'b1, 20);

    // Nominal frame, then a repeat 40 ms later, then a stale repeat.
    expect_valid(0, 32'h20DF_5BA4);
    expect_valid(1, 32'h20DF_5BA4);
    send_frame(32'h20DF_5BA4, 32, -1, 0, 1'b1);
    lvl(1'b1, 4000);
    push(0, K_REPEAT, last0);
    push(1, K_REPEAT, last1);
    send_repeat();
    lvl(1'b1, 15000);
    send_repeat();
    lvl(1'b1, 200);

    // Bit 20 space of 110 ticks falls between the 0 and 1 windows.
    expect_err(0);
    expect_err(1);
    send_frame(32'h20DF_5BA4, 20, 19, 110, 1'b1);
    lvl(1'b1, 200);

    // Command byte not matching its complement.
    expect_err(0);
    expect_valid(1, 32'h20DF_5AA4);
    send_frame(32'h20DF_5AA4, 32, -1, 0, 1'b1);
    lvl(1'b1, 200);

    // Stretched timing with glitches in every space.
    set_timing(8);
    glitch_en = 1'b1;
    expect_valid(0, 32'h20DF_5AA5);
    expect_valid(1, 32'h20DF_5AA5);
    send_frame(32'h20DF_5AA5, 32, -1, 0, 1'b1);
    glitch_en = 1'b0;
    lvl(1'b1, 200);

    // Reset after 16 bits, then a shortened-timing full frame.
    set_timing(-8);
    send_frame(32'h20DF_5AA5, 16, -1, 0, 1'b0);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    last0 = 32'h0;
    last1 = 32'h0;
    check_eq("mid-frame reset code dut0", code0, 32'h0);
    check_eq("mid-frame reset code dut1", code1, 32'h0);
    rst_n = 1'b1;
    lvl(1'b1, 200);
    expect_valid(0, 32'h20DF_5AA5);
    expect_valid(1, 32'h20DF_5AA5);
    send_frame(32'h20DF_5AA5, 32, -1, 0, 1'b1);
    lvl(1'b1, 300);

    checks++;
    if (exp_q0.size() != 0) begin
      errors++;
      $display("FAIL dut0 pending events: got %0d left, required 0", exp_q0.size());
    end
    checks++;
    if (exp_q1.size() != 0) begin
      errors++;
      $display("FAIL dut1 pending events: got %0d left, required 0", exp_q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
